// File: rtl/fp_pkg.sv
// Shared definitions for the FP add/sub alignment front end.
// Field offsets, FSM encoding and the shift saturation limit.
package fp_pkg;

  localparam int MANT_W   = 23;
  localparam int EXP_W    = 8;
  localparam int FRAC_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_OUT
  } state_t;

  function automatic int sign_pos(int m, int e);
    return m + e;
  endfunction

  function automatic int exp_lsb(int m);
    return m;
  endfunction

  function automatic int shift_limit(int m);
    return m + 1;
  endfunction

endpackage

// File: rtl/fp_unpack_cmp.sv
// Combinational unpack, hidden-bit insertion, magnitude order
// and saturated exponent difference for an operand pair.
module fp_unpack_cmp
  import fp_pkg::*;
#(
  parameter int Mantissa_Size = MANT_W,
  parameter int Exponent_Size = EXP_W
) (
  input  logic [Mantissa_Size+Exponent_Size:0] op_a,
  input  logic [Mantissa_Size+Exponent_Size:0] op_b,
  input  logic                                 op_sub,
  output logic                                 a_big,
  output logic                                 big_sign,
  output logic                                 eff_sub,
  output logic [Mantissa_Size:0]               big_mant,
  output logic [Mantissa_Size:0]               small_mant,
  output logic [Exponent_Size-1:0]             big_exp,
  output logic [Exponent_Size-1:0]             small_exp,
  output logic [Exponent_Size-1:0]             shifts,
  output logic                                 diff_zero
);

  localparam int M  = Mantissa_Size;
  localparam int E  = Exponent_Size;
  localparam int SP = sign_pos(M, E);
  localparam int EL = exp_lsb(M);
  localparam logic [E-1:0] LIMIT = E'(shift_limit(M));

  logic [E-1:0] exp_a, exp_b;
  logic [E-1:0] eexp_a, eexp_b;
  logic [E-1:0] diff;
  logic [M:0]   mant_a, mant_b;

  always_comb begin
    exp_a  = op_a[EL +: E];
    exp_b  = op_b[EL +: E];
    // denormals behave as exponent 1 with no hidden bit
    eexp_a = (exp_a == '0) ? E'(1) : exp_a;
    eexp_b = (exp_b == '0) ? E'(1) : exp_b;
    mant_a = {exp_a != '0, op_a[FRAC_LSB +: M]};
    mant_b = {exp_b != '0, op_b[FRAC_LSB +: M]};

    a_big = {eexp_a, mant_a} >= {eexp_b, mant_b};
    eff_sub = op_a[SP] ^ op_b[SP] ^ op_sub;

    big_sign   = a_big ? op_a[SP] : op_b[SP];
    big_mant   = a_big ? mant_a : mant_b;
    small_mant = a_big ? mant_b : mant_a;
    big_exp    = a_big ? eexp_a : eexp_b;
    small_exp  = a_big ? eexp_b : eexp_a;

    diff      = big_exp - small_exp;
    shifts    = (diff > LIMIT) ? LIMIT : diff;
    diff_zero = (diff == '0);
  end

endmodule

// File: rtl/fp_align_ctrl.sv
// Alignment front end: orders operands, drives shift_register,
// then hands the aligned pair to the adder over valid/ready.
module fp_align_ctrl
  import fp_pkg::*;
#(
  parameter int Mantissa_Size = MANT_W,
  parameter int Exponent_Size = EXP_W
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [Mantissa_Size+Exponent_Size:0] op_a,
  input  logic [Mantissa_Size+Exponent_Size:0] op_b,
  input  logic                                 op_sub,
  output logic                                 sr_load,
  output logic [Mantissa_Size:0]               sr_mantissa,
  output logic [Exponent_Size-1:0]             sr_exponent,
  output logic [Exponent_Size-1:0]             sr_no_of_shifts,
  output logic                                 sr_direction,
  input  logic [Mantissa_Size:0]               sr_shiftedMantissa,
  input  logic                                 sr_done,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [Mantissa_Size:0]               big_mantissa,
  output logic [Mantissa_Size:0]               small_mantissa,
  output logic [Exponent_Size-1:0]             common_exponent,
  output logic                                 big_sign,
  output logic                                 eff_sub,
  output logic                                 swapped
);

  localparam int M = Mantissa_Size;
  localparam int E = Exponent_Size;

  state_t state, state_n;
  logic   wait_first;

  logic         u_a_big, u_big_sign, u_eff_sub, u_diff_zero;
  logic [M:0]   u_big_mant, u_small_mant;
  logic [E-1:0] u_big_exp, u_small_exp, u_shifts;
  logic [E-1:0] small_exp;
  logic [E-1:0] shifts;

  fp_unpack_cmp #(
    .Mantissa_Size(M),
    .Exponent_Size(E)
  ) u_cmp (
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .a_big     (u_a_big),
    .big_sign  (u_big_sign),
    .eff_sub   (u_eff_sub),
    .big_mant  (u_big_mant),
    .small_mant(u_small_mant),
    .big_exp   (u_big_exp),
    .small_exp (u_small_exp),
    .shifts    (u_shifts),
    .diff_zero (u_diff_zero)
  );

  logic accept;
  logic capture;

  assign in_ready  = (state == S_IDLE) & ~reset;
  assign sr_load   = (state == S_LOAD) & ~reset;
  assign out_valid = (state == S_OUT) & ~reset;
  assign accept    = in_ready & in_valid;
  // the first WAIT cycle may still see done from the previous job
  assign capture   = (state == S_WAIT) & ~wait_first & sr_done;

  assign sr_direction    = 1'b1;
  assign sr_mantissa     = small_mantissa;
  assign sr_exponent     = small_exp;
  assign sr_no_of_shifts = shifts;

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (in_valid) state_n = u_diff_zero ? S_OUT : S_LOAD;
      S_LOAD: state_n = S_WAIT;
      S_WAIT: if (capture) state_n = S_OUT;
      S_OUT:  if (out_ready) state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      wait_first      <= 1'b0;
      big_mantissa    <= '0;
      small_mantissa  <= '0;
      common_exponent <= '0;
      small_exp       <= '0;
      shifts          <= '0;
      big_sign        <= 1'b0;
      eff_sub         <= 1'b0;
      swapped         <= 1'b0;
    end else begin
      state      <= state_n;
      wait_first <= (state == S_LOAD);
      if (accept) begin
        big_mantissa    <= u_big_mant;
        small_mantissa  <= u_small_mant;
        common_exponent <= u_big_exp;
        small_exp       <= u_small_exp;
        shifts          <= u_shifts;
        big_sign        <= u_big_sign;
        eff_sub         <= u_eff_sub;
        swapped         <= ~u_a_big;
      end
      if (capture) small_mantissa <= sr_shiftedMantissa;
    end
  end

endmodule

// File: tb/tb_fp_align_ctrl.sv
// Directed bench for fp_align_ctrl with a behavioural
// right-shift responder on the sr_* ports.
module tb_fp_align_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a, op_b;
  logic        op_sub;
  logic        sr_load;
  logic [23:0] sr_mantissa;
  logic [7:0]  sr_exponent;
  logic [7:0]  sr_no_of_shifts;
  logic        sr_direction;
  logic [23:0] sr_shiftedMantissa = '0;
  logic        sr_done = 1'b0;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] big_mantissa, small_mantissa;
  logic [7:0]  common_exponent;
  logic        big_sign, eff_sub, swapped;

  int tests = 0;
  int fails = 0;

  int          lat   = 2;
  bit          stale = 1'b0;
  int          cnt   = -1;
  logic [23:0] sh_val = '0;

  fp_align_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .op_a              (op_a),
    .op_b              (op_b),
    .op_sub            (op_sub),
    .sr_load           (sr_load),
    .sr_mantissa       (sr_mantissa),
    .sr_exponent       (sr_exponent),
    .sr_no_of_shifts   (sr_no_of_shifts),
    .sr_direction      (sr_direction),
    .sr_shiftedMantissa(sr_shiftedMantissa),
    .sr_done           (sr_done),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .big_mantissa      (big_mantissa),
    .small_mantissa    (small_mantissa),
    .common_exponent   (common_exponent),
    .big_sign          (big_sign),
    .eff_sub           (eff_sub),
    .swapped           (swapped)
  );

  always #5 clk = ~clk;

  // shift responder; optional stale done right after load
  always @(posedge clk) begin
    if (sr_load) begin
      sr_done            <= stale;
      sr_shiftedMantissa <= 24'h5A5A5A;
      sh_val             <= sr_mantissa >> sr_no_of_shifts;
      cnt                <= lat;
    end else if (cnt == 0) begin
      sr_done            <= 1'b1;
      sr_shiftedMantissa <= sh_val;
      cnt                <= -1;
    end else if (cnt > 0) begin
      sr_done <= 1'b0;
      cnt     <= cnt - 1;
    end else begin
      sr_done <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic sub);
    @(negedge clk);
    op_a     = a;
    op_b     = b;
    op_sub   = sub;
    in_valid = 1'b1;
    chk("send_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_sub    = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sr_load", {31'd0, sr_load}, 32'd0);
    chk("rst_dir", {31'd0, sr_direction}, 32'd1);
    chk("rst_big", {8'd0, big_mantissa}, 32'd0);
    chk("rst_cexp", {24'd0, common_exponent}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // A exp 10 vs B exp 5 with frac .5
    lat = 2; stale = 1'b0;
    send({1'b0, 8'd10, 23'd0}, {1'b0, 8'd5, 23'h400000}, 1'b0);
    chk("t1_load", {31'd0, sr_load}, 32'd1);
    chk("t1_shifts", {24'd0, sr_no_of_shifts}, 32'd5);
    chk("t1_sr_mant", {8'd0, sr_mantissa}, 32'hC00000);
    chk("t1_sr_exp", {24'd0, sr_exponent}, 32'd5);
    chk("t1_dir", {31'd0, sr_direction}, 32'd1);
    @(negedge clk);
    chk("t1_load_pulse", {31'd0, sr_load}, 32'd0);
    chk("t1_busy", {31'd0, in_ready}, 32'd0);
    wait_out("t1");
    chk("t1_big", {8'd0, big_mantissa}, 32'h800000);
    chk("t1_small", {8'd0, small_mantissa}, 32'h060000);
    chk("t1_cexp", {24'd0, common_exponent}, 32'd10);
    chk("t1_swapped", {31'd0, swapped}, 32'd0);
    chk("t1_eff_sub", {31'd0, eff_sub}, 32'd0);
    drain("t1");

    // B larger, stale done in first WAIT cycle, hold in OUT
    lat = 0; stale = 1'b1;
    send({1'b1, 8'd3, 23'd0}, {1'b0, 8'd9, 23'd0}, 1'b0);
    chk("t2_shifts", {24'd0, sr_no_of_shifts}, 32'd6);
    chk("t2_sr_mant", {8'd0, sr_mantissa}, 32'h800000);
    wait_out("t2");
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_small", {8'd0, small_mantissa}, 32'h020000);
      chk("t2_hold_cexp", {24'd0, common_exponent}, 32'd9);
      chk("t2_hold_swapped", {31'd0, swapped}, 32'd1);
      chk("t2_hold_sign", {31'd0, big_sign}, 32'd0);
      chk("t2_hold_eff_sub", {31'd0, eff_sub}, 32'd1);
      chk("t2_hold_ready", {31'd0, in_ready}, 32'd0);
      chk("t2_hold_valid", {31'd0, out_valid}, 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op_a      = {1'b0, 8'd50, 23'd0};
    op_b      = {1'b0, 8'd40, 23'd0};
    chk("t2_no_same_cycle", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("t2_drop", {31'd0, out_valid}, 32'd0);
    chk("t2_idle", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    chk("t2_not_taken", {31'd0, sr_load | out_valid}, 32'd0);

    // equal exponents: direct to OUT
    stale = 1'b0; lat = 2;
    send({1'b0, 8'd7, 23'd1}, {1'b0, 8'd7, 23'd0}, 1'b0);
    chk("t3_lat", {31'd0, out_valid}, 32'd1);
    chk("t3_no_load", {31'd0, sr_load}, 32'd0);
    chk("t3_swapped", {31'd0, swapped}, 32'd0);
    chk("t3_big", {8'd0, big_mantissa}, 32'h800001);
    chk("t3_small", {8'd0, small_mantissa}, 32'h800000);
    drain("t3");

    // saturated shift
    lat = 3;
    send({1'b0, 8'd120, 23'd0}, {1'b0, 8'd20, 23'd0}, 1'b1);
    chk("t4_shifts", {24'd0, sr_no_of_shifts}, 32'd24);
    wait_out("t4");
    chk("t4_small", {8'd0, small_mantissa}, 32'h000000);
    chk("t4_cexp", {24'd0, common_exponent}, 32'd120);
    chk("t4_eff_sub", {31'd0, eff_sub}, 32'd1);
    drain("t4");

    // reset during WAIT
    lat = 6;
    send({1'b0, 8'd10, 23'd0}, {1'b0, 8'd5, 23'h400000}, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    chk("r_ready_in_rst", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("r_valid", {31'd0, out_valid}, 32'd0);
    chk("r_load", {31'd0, sr_load}, 32'd0);
    chk("r_big_clr", {8'd0, big_mantissa}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("r_ready_after", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("r_no_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end
    lat = 1;
    send({1'b0, 8'd12, 23'd0}, {1'b0, 8'd10, 23'h200000}, 1'b0);
    chk("r2_shifts", {24'd0, sr_no_of_shifts}, 32'd2);
    wait_out("r2");
    chk("r2_small", {8'd0, small_mantissa}, 32'h280000);
    chk("r2_cexp", {24'd0, common_exponent}, 32'd12);
    drain("r2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
